// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and default sizes for the 2R1W data memory
package data_mem_pkg;

    localparam int DATA_MEM_DW = 8;
    localparam int DATA_MEM_AW = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/data_mem_clr_fsm.sv
// rtl/data_mem_clr_fsm.sv - zero-fill sweep controller: FSM, sweep address, Busy/ClearDone
module data_mem_clr_fsm
    import data_mem_pkg::*;
#(
    parameter int AW = DATA_MEM_AW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          ClearReq,
    output logic          Busy,
    output logic          ClearDone,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    clr_state_e  state, state_next;
    logic [AW:0] clr_cnt, clr_cnt_next;
    logic [AW:0] cnt_inc;
    logic        done_next;

    // One extra counter bit lets the last-address test look at the carry instead of a wrapped compare
    assign cnt_inc  = clr_cnt + (AW+1)'(1);
    assign Busy     = (state == CLEAR);
    assign clr_we   = Busy;
    assign clr_addr = clr_cnt[AW-1:0];

    // State, sweep address and done pulse registers; reset restarts the sweep from address 0
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            ClearDone <= 1'b0;
        end else begin
            state     <= state_next;
            clr_cnt   <= clr_cnt_next;
            ClearDone <= done_next;
        end
    end

    // Next-state: start on request from IDLE, step the address each CLEAR cycle, finish after the top word
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                if (ClearReq) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end
            end
            CLEAR: begin
                if (cnt_inc[AW]) begin
                    state_next   = IDLE;
                    clr_cnt_next = '0;
                    done_next    = 1'b1;
                end else begin
                    clr_cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next   = IDLE;
                clr_cnt_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_2r1w.sv
// rtl/data_mem_2r1w.sv - two-read one-write data memory with zero-fill sweep; DATA_MEM_BYPASS_EN selects write-first reads
module data_mem_2r1w
    import data_mem_pkg::*;
#(
    parameter int DW = DATA_MEM_DW,
    parameter int AW = DATA_MEM_AW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          ClearReq,
    input  logic          WriteEn,
    input  logic [AW-1:0] WrAddr,
    input  logic [DW-1:0] DataIn,
    input  logic          RdEnA,
    input  logic [AW-1:0] RdAddrA,
    input  logic          RdEnB,
    input  logic [AW-1:0] RdAddrB,
    output logic [DW-1:0] DataOutA,
    output logic [DW-1:0] DataOutB,
    output logic          ValidA,
    output logic          ValidB,
    output logic          Busy,
    output logic          ClearDone
);

    logic [DW-1:0] core [2**AW];

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          user_we;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          rd_go_a, rd_go_b;
    logic [DW-1:0] rd_data_a, rd_data_b;

    data_mem_clr_fsm #(
        .AW (AW)
    ) u_clr_fsm (
        .Clk       (Clk),
        .Reset     (Reset),
        .ClearReq  (ClearReq),
        .Busy      (Busy),
        .ClearDone (ClearDone),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // User traffic is locked out while the sweep owns the array or reset is asserted
    assign user_we = WriteEn & ~Busy & ~Reset;
    assign rd_go_a = RdEnA & ~Busy & ~Reset;
    assign rd_go_b = RdEnB & ~Busy & ~Reset;

    // Single write port: the sweep's zero write takes precedence over the user write
    always_comb begin
        mem_we    = clr_we | user_we;
        mem_waddr = WrAddr;
        mem_wdata = DataIn;
        if (clr_we) begin
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end
    end

    // Storage array, no reset so it maps onto block RAM
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            core[mem_waddr] <= mem_wdata;
        end
    end

`ifdef DATA_MEM_BYPASS_EN
    // Write-first: a same-cycle write to the read address forwards the incoming data
    always_comb begin
        rd_data_a = core[RdAddrA];
        rd_data_b = core[RdAddrB];
        if (user_we && (WrAddr == RdAddrA)) begin
            rd_data_a = DataIn;
        end
        if (user_we && (WrAddr == RdAddrB)) begin
            rd_data_b = DataIn;
        end
    end
`else
    // Read-first: reads see the array contents from before this edge's write
    always_comb begin
        rd_data_a = core[RdAddrA];
        rd_data_b = core[RdAddrB];
    end
`endif

    // Read port A output register and valid pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            DataOutA <= '0;
            ValidA   <= 1'b0;
        end else begin
            ValidA <= rd_go_a;
            if (rd_go_a) begin
                DataOutA <= rd_data_a;
            end
        end
    end

    // Read port B output register and valid pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            DataOutB <= '0;
            ValidB   <= 1'b0;
        end else begin
            ValidB <= rd_go_b;
            if (rd_go_b) begin
                DataOutB <= rd_data_b;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_2r1w.sv
// tb/tb_data_mem_2r1w.sv - self-checking bench for data_mem_2r1w (vector table plus sweep/reset sequences)
module tb_data_mem_2r1w;

`ifdef DATA_MEM_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // main instance, AW=8
    logic       Clk = 1'b0;
    logic       Reset, ClearReq, WriteEn, RdEnA, RdEnB;
    logic [7:0] WrAddr, DataIn, RdAddrA, RdAddrB;
    logic [7:0] DataOutA, DataOutB;
    logic       ValidA, ValidB, Busy, ClearDone;

    // small instance, AW=4, for sweep timing
    logic       Reset4, ClearReq4, RdEnA4;
    logic [3:0] RdAddrA4;
    logic [7:0] DataOutA4, DataOutB4;
    logic       ValidA4, ValidB4, Busy4, ClearDone4;

    int         n_vec  = 0;
    int         n_fail = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] last_a, last_b;

    typedef struct {
        logic       we;
        logic [7:0] waddr;
        logic [7:0] wdata;
        logic       rea;
        logic [7:0] ra;
        logic       reb;
        logic [7:0] rb;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    vec_t vecs[10];

    always #5 Clk = ~Clk;

    data_mem_2r1w #(.DW(8), .AW(8)) dut (
        .Clk(Clk), .Reset(Reset), .ClearReq(ClearReq),
        .WriteEn(WriteEn), .WrAddr(WrAddr), .DataIn(DataIn),
        .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdEnB(RdEnB), .RdAddrB(RdAddrB),
        .DataOutA(DataOutA), .DataOutB(DataOutB), .ValidA(ValidA), .ValidB(ValidB),
        .Busy(Busy), .ClearDone(ClearDone)
    );

    data_mem_2r1w #(.DW(8), .AW(4)) dut4 (
        .Clk(Clk), .Reset(Reset4), .ClearReq(ClearReq4),
        .WriteEn(1'b0), .WrAddr(4'h0), .DataIn(8'h00),
        .RdEnA(RdEnA4), .RdAddrA(RdAddrA4), .RdEnB(1'b0), .RdAddrB(4'h0),
        .DataOutA(DataOutA4), .DataOutB(DataOutB4), .ValidA(ValidA4), .ValidB(ValidB4),
        .Busy(Busy4), .ClearDone(ClearDone4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // scoreboard: every valid pulse pops the value expected when the read was driven
    always @(negedge Clk) begin
        if (ValidA) begin
            if (qa.size() == 0) check("stray ValidA", 1, 0);
            else check("DataOutA", DataOutA, qa.pop_front());
        end
        if (ValidB) begin
            if (qb.size() == 0) check("stray ValidB", 1, 0);
            else check("DataOutB", DataOutB, qb.pop_front());
        end
    end

    task automatic sweep4_restart(input int hold);
        int done_at;
        int busy_n;
        ClearReq4 = 1'b1;
        step();
        ClearReq4 = 1'b0;
        repeat (9) step();
        Reset4 = 1'b1;
        repeat (hold) step();
        Reset4 = 1'b0;
        check("Busy4 after mid-sweep reset", Busy4, 1);
        done_at = -1;
        busy_n  = 0;
        for (int i = 0; i < 40; i++) begin
            if (Busy4) busy_n++;
            if (ClearDone4 && done_at < 0) done_at = i;
            step();
        end
        check("restart ClearDone latency", done_at, 16);
        check("restart busy cycles", busy_n, 16);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n, done_n, done_at, k;

        vecs[0] = '{1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 1'b1, 8'h10, 8'hA5, 8'hA5};
        vecs[2] = '{1'b1, 8'h22, 8'h11, 1'b1, 8'h10, 1'b0, 8'h00, 8'hA5, 8'h00};
        vecs[3] = '{1'b1, 8'h22, 8'h77, 1'b1, 8'h22, 1'b1, 8'h22,
                    (BYP ? 8'h77 : 8'h11), (BYP ? 8'h77 : 8'h11)};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h22, 1'b1, 8'h00, 8'h77, 8'h00};
        vecs[5] = '{1'b1, 8'hFF, 8'h3C, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h00, (BYP ? 8'h3C : 8'h00)};
        vecs[6] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 8'h10, 8'h3C, 8'hA5};
        vecs[7] = '{1'b1, 8'h00, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[8] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 8'h22, 8'h5A, 8'h77};
        vecs[9] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00};

        Reset = 1'b1; ClearReq = 1'b0; WriteEn = 1'b0; WrAddr = '0; DataIn = '0;
        RdEnA = 1'b0; RdAddrA = '0; RdEnB = 1'b0; RdAddrB = '0;
        Reset4 = 1'b1; ClearReq4 = 1'b0; RdEnA4 = 1'b0; RdAddrA4 = '0;
        last_a = 8'h00; last_b = 8'h00;
        step();
        Reset = 1'b0; Reset4 = 1'b0;

        // reset state
        check("reset Busy", Busy, 1);
        check("reset ValidA", ValidA, 0);
        check("reset ValidB", ValidB, 0);
        check("reset DataOutA", DataOutA, 8'h00);
        check("reset DataOutB", DataOutB, 8'h00);
        check("reset ClearDone", ClearDone, 0);

        // AW=4 sweep after a one-cycle reset: 16 busy cycles, then one ClearDone
        busy_n = 0; done_n = 0; done_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (Busy4) busy_n++;
            if (ClearDone4) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            step();
        end
        check("AW4 busy cycles", busy_n, 16);
        check("AW4 ClearDone count", done_n, 1);
        check("AW4 ClearDone cycle", done_at, 16);
        for (int a = 0; a < 16; a++) begin
            RdEnA4 = 1'b1;
            RdAddrA4 = 4'(a);
            step();
            check("AW4 read valid", ValidA4, 1);
            check("AW4 read zero", DataOutA4, 8'h00);
            check("AW4 port B idle", {DataOutB4, ValidB4}, 9'h0);
        end
        RdEnA4 = 1'b0;
        step();

        // main instance finishes its initial sweep
        for (k = 0; k < 400 && !ClearDone; k++) step();
        check("initial ClearDone seen", ClearDone, 1);
        step();

        // vector table
        for (int i = 0; i < 10; i++) begin
            WriteEn = vecs[i].we;  WrAddr  = vecs[i].waddr; DataIn  = vecs[i].wdata;
            RdEnA   = vecs[i].rea; RdAddrA = vecs[i].ra;
            RdEnB   = vecs[i].reb; RdAddrB = vecs[i].rb;
            if (vecs[i].rea) qa.push_back(vecs[i].exp_a);
            if (vecs[i].reb) qb.push_back(vecs[i].exp_b);
            step();
            check("vec ValidA", ValidA, vecs[i].rea);
            check("vec ValidB", ValidB, vecs[i].reb);
            if (vecs[i].rea) last_a = vecs[i].exp_a;
            else check("vec DataOutA hold", DataOutA, last_a);
            if (vecs[i].reb) last_b = vecs[i].exp_b;
            else check("vec DataOutB hold", DataOutB, last_b);
        end
        WriteEn = 1'b0; RdEnA = 1'b0; RdEnB = 1'b0;
        step();

        // ClearReq twice, 3 cycles apart, with user traffic during the sweep
        busy_n = 0; done_n = 0;
        ClearReq = 1'b1;
        step();
        ClearReq = 1'b0;
        check("Busy after ClearReq", Busy, 1);
        WriteEn = 1'b1; WrAddr = 8'h05; DataIn = 8'hFF;
        RdEnA = 1'b1; RdAddrA = 8'h05; RdEnB = 1'b1; RdAddrB = 8'h05;
        for (int i = 0; i < 400; i++) begin
            if (Busy) busy_n++;
            if (ClearDone) done_n++;
            if (i < 10) check("ValidA during sweep", {ValidA, ValidB}, 2'b00);
            ClearReq = (i == 2);
            if (i == 10) begin
                WriteEn = 1'b0; RdEnA = 1'b0; RdEnB = 1'b0;
            end
            step();
        end
        check("sweep busy cycles", busy_n, 256);
        check("sweep ClearDone count", done_n, 1);
        check("DataOutA held over sweep", DataOutA, last_a);
        check("DataOutB held over sweep", DataOutB, last_b);

        RdEnA = 1'b1; RdAddrA = 8'h05; qa.push_back(8'h00);
        RdEnB = 1'b1; RdAddrB = 8'h10; qb.push_back(8'h00);
        step();
        check("post-sweep ValidA", ValidA, 1);
        check("post-sweep ValidB", ValidB, 1);
        RdEnA = 1'b0; RdEnB = 1'b0;
        step();

        // AW=4 reset at sweep address 9, held 1 and then 3 cycles
        sweep4_restart(1);
        sweep4_restart(3);

        // reset clears a non-zero output register
        WriteEn = 1'b1; WrAddr = 8'h44; DataIn = 8'hC3;
        step();
        WriteEn = 1'b0;
        RdEnA = 1'b1; RdAddrA = 8'h44; qa.push_back(8'hC3);
        step();
        RdEnA = 1'b0;
        step();
        check("DataOutA before reset", DataOutA, 8'hC3);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("mid-use reset DataOutA", DataOutA, 8'h00);
        check("mid-use reset ValidA", ValidA, 0);
        check("mid-use reset Busy", Busy, 1);
        check("mid-use reset ClearDone", ClearDone, 0);
        step();
        check("scoreboard A drained", qa.size(), 0);
        check("scoreboard B drained", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
